// File: rtl/adc_vol_filter.sv
// Moving-average filter on one ADC channel, followed by a serial
// divider that scales the average to millivolts (avg * 5000 / 4095).
module adc_vol_filter #(
  parameter int LOG2_AVG = 3
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        response_valid,
  input  logic [4:0]  response_channel,
  input  logic [11:0] response_data,
  input  logic [4:0]  sel_channel,
  output logic [12:0] vol,
  output logic        vol_valid,
  output logic [11:0] sample_avg,
  output logic        busy
);

  localparam int N  = 1 << LOG2_AVG;
  localparam int SW = 12 + LOG2_AVG;
  localparam logic [LOG2_AVG:0] FILL_N  = (LOG2_AVG+1)'(N);
  localparam logic [LOG2_AVG:0] FILL_N1 = (LOG2_AVG+1)'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [11:0]         win [N];
  logic [LOG2_AVG-1:0] ptr;
  logic [LOG2_AVG:0]   fill;
  logic [SW-1:0]       sum;
  logic [SW-1:0]       sum_next;
  logic [4:0]          prev_sel;
  logic [11:0]         evict;
  logic                full;
  logic                full_after;
  logic                flush;
  logic                accept;
  logic                qual;

  logic [1:0]  state;
  logic        pending;
  logic [24:0] num;
  logic [24:0] quo;
  logic [11:0] rem;
  logic [4:0]  cnt;
  logic [12:0] rem_sh;
  logic [12:0] rem_nx;
  logic        ge;

  assign full       = (fill == FILL_N);
  assign full_after = full || (fill == FILL_N1);
  assign flush      = (sel_channel != prev_sel);
  assign accept     = response_valid && !flush &&
                      (response_channel == sel_channel);
  assign qual       = accept && full_after;
  assign evict      = full ? win[ptr] : 12'd0;
  assign sum_next   = sum + SW'(response_data) - SW'(evict);
  assign sample_avg = full ? sum[SW-1:LOG2_AVG] : 12'd0;
  assign busy       = (state != S_IDLE);

  // one restoring-division step per cycle, numerator shifted in MSB first
  assign rem_sh = {rem, num[24]};
  assign ge     = (rem_sh >= 13'd4095);
  assign rem_nx = ge ? (rem_sh - 13'd4095) : rem_sh;

  always_ff @(posedge Clk) begin
    if (accept) win[ptr] <= response_data;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ptr      <= '0;
      fill     <= '0;
      sum      <= '0;
      prev_sel <= sel_channel;
    end else begin
      prev_sel <= sel_channel;
      if (flush) begin
        ptr  <= '0;
        fill <= '0;
        sum  <= '0;
      end else if (accept) begin
        ptr <= ptr + 1'b1;
        sum <= sum_next;
        if (!full) fill <= fill + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= S_IDLE;
      pending   <= 1'b0;
      num       <= '0;
      quo       <= '0;
      rem       <= '0;
      cnt       <= '0;
      vol       <= '0;
      vol_valid <= 1'b0;
    end else begin
      vol_valid <= 1'b0;
      // a new sample during a conversion outranks LOAD clearing pending
      if (flush)
        pending <= 1'b0;
      else if (qual && state != S_IDLE)
        pending <= 1'b1;
      else if (state == S_LOAD)
        pending <= 1'b0;
      case (state)
        S_IDLE: begin
          if (qual || (pending && !flush)) state <= S_LOAD;
        end
        S_LOAD: begin
          num   <= 25'(sample_avg) * 25'd5000;
          quo   <= '0;
          rem   <= '0;
          cnt   <= '0;
          state <= S_DIV;
        end
        S_DIV: begin
          num <= {num[23:0], 1'b0};
          quo <= {quo[23:0], ge};
          rem <= rem_nx[11:0];
          if (cnt == 5'd24) state <= S_DONE;
          else cnt <= cnt + 1'b1;
        end
        default: begin
          vol       <= quo[12:0];
          vol_valid <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_vol_filter.sv
// Random and directed stimulus for adc_vol_filter, checked every cycle
// against a queue-based window and conversion-timeline model.
module tb_adc_vol_filter;

  localparam int L = 3;
  localparam int N = 1 << L;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        response_valid = 1'b0;
  logic [4:0]  response_channel = '0;
  logic [11:0] response_data = '0;
  logic [4:0]  sel_channel = 5'd1;
  logic [12:0] vol;
  logic        vol_valid;
  logic [11:0] sample_avg;
  logic        busy;

  adc_vol_filter #(.LOG2_AVG(L)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .response_valid(response_valid),
    .response_channel(response_channel),
    .response_data(response_data),
    .sel_channel(sel_channel),
    .vol(vol),
    .vol_valid(vol_valid),
    .sample_avg(sample_avg),
    .busy(busy)
  );

  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_err = 0;

  int     q[$];
  int     e = 0;
  int     m_prev = 1;
  bit     m_pend = 0;
  bit     conv_on = 0;
  int     load_at = 0;
  int     done_at = 0;
  int     cap = 0;
  int     exp_vol = 0;
  bit     exp_vv = 0;
  int     vv_seen = 0;

  task automatic chk(input string tag, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, got, want, e);
    end
  endtask

  function automatic int win_avg();
    int s = 0;
    if (q.size() != N) return 0;
    foreach (q[i]) s += q[i];
    return s / N;
  endfunction

  task automatic tick();
    bit flush, acc, active, start;
    int old_avg;
    @(posedge Clk);
    e++;
    exp_vv = 0;
    if (Reset) begin
      q.delete();
      m_pend  = 0;
      conv_on = 0;
      exp_vol = 0;
      m_prev  = sel_channel;
    end else begin
      flush   = (sel_channel != m_prev);
      m_prev  = sel_channel;
      acc     = response_valid && !flush && (response_channel == sel_channel);
      old_avg = win_avg();
      active  = conv_on && (e <= done_at);
      start   = 0;
      if (conv_on && e == load_at) begin
        cap    = old_avg * 5000 / 4095;
        m_pend = 0;
      end
      if (flush) begin
        q.delete();
        m_pend = 0;
      end
      if (acc) begin
        q.push_back(int'(response_data));
        if (q.size() > N) void'(q.pop_front());
        if (q.size() == N) begin
          if (active) m_pend = 1;
          else start = 1;
        end
      end
      if (conv_on && e == done_at) begin
        exp_vol = cap;
        exp_vv  = 1;
      end
      if (!active && m_pend) start = 1;
      if (start) begin
        conv_on = 1;
        load_at = e + 1;
        done_at = e + 27;
      end
    end
    @(negedge Clk);
    if (vol_valid) vv_seen++;
    chk("vol_valid", int'(vol_valid), int'(exp_vv));
    chk("vol", int'(vol), exp_vol);
    chk("busy", int'(busy), int'(conv_on && e < done_at));
    chk("sample_avg", int'(sample_avg), win_avg());
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input int ch, input int d);
    response_valid   = 1'b1;
    response_channel = 5'(ch);
    response_data    = 12'(d);
    tick();
    response_valid   = 1'b0;
  endtask

  initial begin
    idle(3);
    Reset = 1'b0;
    idle(1);
    chk("rst_vol", int'(vol), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_avg", int'(sample_avg), 0);

    vv_seen = 0;
    for (int i = 0; i < 7; i++) begin
      send(1, 4095);
      idle(1);
    end
    chk("no_vv_before_full", vv_seen, 0);
    send(1, 4095);
    idle(30);
    chk("full_vv_count", vv_seen, 1);
    chk("full_vol", int'(vol), 5000);
    chk("full_avg", int'(sample_avg), 4095);

    for (int i = 0; i < 8; i++) send(1, 2048);
    idle(60);
    chk("mid_vol", int'(vol), 2500);
    for (int i = 0; i < 8; i++) send(1, (i % 2) ? 4095 : 0);
    idle(60);
    chk("alt_avg", int'(sample_avg), 2047);
    chk("alt_vol", int'(vol), 2499);

    for (int i = 0; i < 8; i++) begin
      send(2, 0);
      send(1, 4095);
    end
    idle(60);
    chk("interleave_vol", int'(vol), 5000);

    sel_channel = 5'd3;
    idle(2);
    for (int i = 0; i < 7; i++) begin
      send(1, 0);
      send(3, 1000);
    end
    idle(30);
    chk("hold_vol", int'(vol), 5000);
    send(3, 1000);
    idle(30);
    chk("ch3_vol", int'(vol), 1221);

    vv_seen = 0;
    for (int i = 0; i < 20; i++) begin
      send(3, int'($urandom_range(0, 4095)));
      idle(4);
    end
    idle(60);
    chk("overrun_vol", int'(vol), win_avg() * 5000 / 4095);
    chk("overrun_conv", int'(vv_seen >= 3), 1);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) sel_channel = 5'($urandom_range(0, 3));
      response_valid   = ($urandom_range(0, 3) == 0);
      response_channel = 5'($urandom_range(0, 3));
      response_data    = 12'($urandom_range(0, 4095));
      tick();
    end
    response_valid = 1'b0;
    idle(60);

    sel_channel = 5'd1;
    idle(2);
    for (int i = 0; i < 8; i++) send(1, 3000);
    idle(10);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("rdiv_busy", int'(busy), 0);
    chk("rdiv_vol", int'(vol), 0);
    vv_seen = 0;
    idle(30);
    for (int i = 0; i < 7; i++) send(1, 3000);
    idle(30);
    chk("rdiv_no_vv", vv_seen, 0);
    send(1, 3000);
    idle(30);
    chk("rdiv_vol_after", int'(vol), 3000 * 5000 / 4095);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
